// File: rtl/flash_arbiter.sv
// Two-master round-robin arbiter in front of the SPI flash controller bus port.
// Slave retries are re-issued after a fixed idle gap, up to a bounded count.
module flash_arbiter #(
    parameter int RETRY_GAP = 64,
    parameter int MAX_RETRY = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_rty_o,
    input  logic [23:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_rty_o,
    output logic [23:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_rty_i
);
    typedef enum logic [2:0] {IDLE, BUSY, WAIT, DONE_ACK, DONE_RTY} state_t;

    localparam logic [15:0] GAP_LOAD    = 16'(RETRY_GAP);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    state_t      state;
    state_t      state_next;
    logic        grant;
    logic        last_grant;
    logic [7:0]  retry_cnt;
    logic [15:0] gap;
    logic        grant_stb;
    logic        any_stb;
    logic        winner;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_next = state;
        any_stb    = m0_stb_i || m1_stb_i;
        grant_stb  = grant ? m1_stb_i : m0_stb_i;
        // A tie goes to the master that did not win last time.
        winner     = (m0_stb_i && m1_stb_i) ? ~last_grant : m1_stb_i;

        case (state)
            IDLE: begin
                if (any_stb) state_next = BUSY;
            end
            BUSY: begin
                if (!grant_stb)   state_next = IDLE;
                else if (s_ack_i) state_next = DONE_ACK;
                else if (s_rty_i) state_next = (retry_cnt >= RETRY_LIMIT) ? DONE_RTY : WAIT;
            end
            WAIT: begin
                if (!grant_stb)        state_next = IDLE;
                else if (gap <= 16'd1) state_next = BUSY;
            end
            DONE_ACK, DONE_RTY: state_next = IDLE;
            default:            state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            retry_cnt  <= 8'd0;
            gap        <= 16'd0;
            s_adr_o    <= 24'd0;
            s_dat_o    <= 32'd0;
            s_we_o     <= 1'b0;
            m0_dat_o   <= 32'd0;
            m1_dat_o   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_stb) begin
                        grant      <= winner;
                        last_grant <= winner;
                        retry_cnt  <= 8'd0;
                        s_adr_o    <= winner ? m1_adr_i : m0_adr_i;
                        s_dat_o    <= winner ? m1_dat_i : m0_dat_i;
                        s_we_o     <= winner ? m1_we_i  : m0_we_i;
                    end
                end
                BUSY: begin
                    if (grant_stb) begin
                        if (s_ack_i) begin
                            if (grant) m1_dat_o <= s_dat_i;
                            else       m0_dat_o <= s_dat_i;
                        end else if (s_rty_i && retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 8'd1;
                            gap       <= GAP_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (gap != 16'd0) gap <= gap - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign s_stb_o  = (state == BUSY);
    assign m0_ack_o = (state == DONE_ACK) && !grant;
    assign m1_ack_o = (state == DONE_ACK) &&  grant;
    assign m0_rty_o = (state == DONE_RTY) && !grant;
    assign m1_rty_o = (state == DONE_RTY) &&  grant;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: stimulus pushes expected completions into a
// scoreboard queue, a monitor pops and compares on every ack/rty pulse.
module tb_flash_arbiter;
    localparam int GAP  = 4;
    localparam int MAXR = 2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [23:0] m_adr  [2];
    logic [31:0] m_wdat [2];
    logic        m_we   [2];
    logic        m_stb  [2];
    logic [31:0] m_dat  [2];
    logic        m_ack  [2];
    logic        m_rty  [2];
    logic [23:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic        s_we_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_rty_i;

    always #5 clk = ~clk;

    flash_arbiter #(.RETRY_GAP(GAP), .MAX_RETRY(MAXR)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_wdat[0]), .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]),
        .m0_dat_o(m_dat[0]), .m0_ack_o(m_ack[0]),  .m0_rty_o(m_rty[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_wdat[1]), .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]),
        .m1_dat_o(m_dat[1]), .m1_ack_o(m_ack[1]),  .m1_rty_o(m_rty[1]),
        .s_adr_o (s_adr_o),  .s_dat_o (s_dat_o),   .s_we_o  (s_we_o),  .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i),  .s_ack_i (s_ack_i),   .s_rty_i (s_rty_i)
    );

    typedef struct packed {
        logic        k;
        logic        rty;
        logic [31:0] dat;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] exp_dat [2];
    int          n_checks = 0;
    int          n_pass   = 0;

    int          slave_lat   = 1;
    bit          rty_always  = 1'b0;
    int          rty_left    = 0;
    logic [31:0] mem [bit [23:0]];
    logic [23:0] seen_adr;
    logic [31:0] seen_wdat;
    logic        seen_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, want);
    endtask

    task automatic push_exp(input logic k, input logic rty, input logic [31:0] dat);
        exp_t e;
        e.k = k; e.rty = rty; e.dat = dat;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] slave_word(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return {8'h5A, a};
    endfunction

    // Slave: respond slave_lat cycles after s_stb_o rises, with rty or ack.
    initial begin
        int hi_cnt;
        hi_cnt  = 0;
        s_ack_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            s_ack_i = 1'b0;
            s_rty_i = 1'b0;
            if (s_stb_o && rst_ni) begin
                if (hi_cnt == slave_lat) begin
                    seen_adr  = s_adr_o;
                    seen_wdat = s_dat_o;
                    seen_we   = s_we_o;
                    if (rty_always || rty_left > 0) begin
                        s_rty_i = 1'b1;
                        if (rty_left > 0) rty_left--;
                    end else begin
                        s_ack_i = 1'b1;
                        s_dat_i = slave_word(s_adr_o);
                    end
                    hi_cnt = 0;
                end else begin
                    hi_cnt++;
                end
            end else begin
                hi_cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops on completion pulses; read data must hold otherwise.
    initial begin
        exp_t e;
        bit   prev_pulse [2];
        prev_pulse[0] = 1'b0;
        prev_pulse[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_pulse[0] = 1'b0;
                prev_pulse[1] = 1'b0;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (m_ack[k] || m_rty[k]) begin
                        check($sformatf("m%0d_pulse_width", k), 32'(prev_pulse[k]), 32'd0);
                        check($sformatf("m%0d_ack_rty_both", k), 32'(m_ack[k] && m_rty[k]), 32'd0);
                        if (exp_q.size() == 0) begin
                            check($sformatf("m%0d_unexpected_pulse", k), 32'(m_ack[k] || m_rty[k]), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("m%0d_pulse_master", k), k, 32'(e.k));
                            check($sformatf("m%0d_pulse_is_rty", k), 32'(m_rty[k]), 32'(e.rty));
                            if (!e.rty) begin
                                check($sformatf("m%0d_read_data", k), m_dat[k], e.dat);
                                exp_dat[k] = e.dat;
                            end else begin
                                check($sformatf("m%0d_dat_on_rty", k), m_dat[k], exp_dat[k]);
                            end
                        end
                    end else begin
                        check($sformatf("m%0d_dat_hold", k), m_dat[k], exp_dat[k]);
                    end
                    prev_pulse[k] = m_ack[k] || m_rty[k];
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_stb"}, 32'(s_stb_o), 32'd0);
        check({tag, "_s_we"},  32'(s_we_o),  32'd0);
        check({tag, "_s_adr"}, 32'(s_adr_o), 32'd0);
        check({tag, "_s_dat"}, s_dat_o,      32'd0);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_m%0d_dat", tag, k), m_dat[k],        32'd0);
            check($sformatf("%s_m%0d_ack", tag, k), 32'(m_ack[k]),   32'd0);
            check($sformatf("%s_m%0d_rty", tag, k), 32'(m_rty[k]),   32'd0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_ni     = 1'b0;
        exp_dat[0] = 32'd0;
        exp_dat[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Master: raise stb and hold it until this master sees ack or rty.
    task automatic master_req(input int k, input logic [23:0] adr, input logic [31:0] wd, input logic we);
        bit done;
        done      = 1'b0;
        m_adr[k]  = adr;
        m_wdat[k] = wd;
        m_we[k]   = we;
        m_stb[k]  = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (m_ack[k] || m_rty[k]) done = 1'b1;
        end
        m_stb[k] = 1'b0;
        check($sformatf("m%0d_completed", k), 32'(done), 32'd1);
    endtask

    // Counts s_stb_o phases and the low gap before each re-issue.
    task automatic watch_phases(input int k, input int exp_phases, input string tag);
        int phases;
        int low_run;
        bit prev_stb;
        bit done;
        phases = 0; low_run = 0; prev_stb = 1'b0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (s_stb_o && !prev_stb) begin
                phases++;
                if (phases > 1) check($sformatf("%s_gap%0d", tag, phases - 1), low_run, GAP);
            end
            low_run  = s_stb_o ? 0 : low_run + 1;
            prev_stb = s_stb_o;
            if (m_ack[k] || m_rty[k]) done = 1'b1;
        end
        check({tag, "_phases"}, phases, exp_phases);
    endtask

    task automatic wait_for_gap(input string tag);
        bit seen_hi;
        bit in_wait;
        seen_hi = s_stb_o;
        in_wait = 1'b0;
        for (int c = 0; c < 50 && !in_wait; c++) begin
            @(negedge clk);
            if (s_stb_o)      seen_hi = 1'b1;
            else if (seen_hi) in_wait = 1'b1;
        end
        check({tag, "_reached_wait"}, 32'(in_wait), 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_adr[k] = 24'd0; m_wdat[k] = 32'd0; m_we[k] = 1'b0; m_stb[k] = 1'b0;
            exp_dat[k] = 32'd0;
        end
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_ni = 1'b1;

        // Single read, slave acks 3 cycles after s_stb_o; master inputs wiggle mid-flight.
        mem[24'h000100] = 32'hDEADBEEF;
        slave_lat = 3;
        @(negedge clk);
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        fork
            master_req(0, 24'h000100, 32'h0, 1'b0);
            begin
                @(negedge clk);
                check("t1_stb_latency", 32'(s_stb_o), 32'd1);
                check("t1_s_adr",       32'(s_adr_o), 32'h000100);
                m_adr[0] = 24'hABCDEF;
                m_we[0]  = 1'b1;
                @(negedge clk);
                check("t1_s_adr_hold", 32'(s_adr_o), 32'h000100);
                check("t1_s_we_hold",  32'(s_we_o),  32'd0);
                repeat (2) @(negedge clk);
                check("t1_ack_not_early", 32'(m_ack[0]), 32'd0);
                check("t1_stb_still_on",  32'(s_stb_o),  32'd1);
                @(negedge clk);
                check("t1_ack_pulse", 32'(m_ack[0]), 32'd1);
                check("t1_m1_ack",    32'(m_ack[1]), 32'd0);
                check("t1_m1_rty",    32'(m_rty[1]), 32'd0);
                @(negedge clk);
                check("t1_ack_clear", 32'(m_ack[0]), 32'd0);
                check("t1_stb_off",   32'(s_stb_o),  32'd0);
                @(negedge clk);
                check("t1_no_regrant", 32'(s_stb_o), 32'd0);
            end
        join

        // Tie right after reset goes to m0, then m1; after a lone m0, the next tie goes to m1.
        apply_reset();
        slave_lat = 1;
        @(negedge clk);
        push_exp(1'b0, 1'b0, 32'h5A000200);
        push_exp(1'b1, 1'b0, 32'h5A000300);
        fork
            master_req(0, 24'h000200, 32'h11111111, 1'b0);
            master_req(1, 24'h000300, 32'hCAFEF00D, 1'b1);
        join
        check("t2_slave_adr",  32'(seen_adr), 32'h000300);
        check("t2_slave_we",   32'(seen_we),  32'd1);
        check("t2_slave_wdat", seen_wdat,     32'hCAFEF00D);
        @(negedge clk);
        push_exp(1'b0, 1'b0, 32'h5A000210);
        master_req(0, 24'h000210, 32'h0, 1'b0);
        @(negedge clk);
        push_exp(1'b1, 1'b0, 32'h5A000310);
        push_exp(1'b0, 1'b0, 32'h5A000220);
        fork
            master_req(0, 24'h000220, 32'h0, 1'b0);
            master_req(1, 24'h000310, 32'h0, 1'b0);
        join

        // Slave always retries: MAX_RETRY+1 phases, each gap GAP cycles, then rty.
        rty_always = 1'b1;
        @(negedge clk);
        push_exp(1'b0, 1'b1, 32'h0);
        fork
            master_req(0, 24'h000600, 32'h0, 1'b0);
            watch_phases(0, MAXR + 1, "t3");
        join
        rty_always = 1'b0;

        // One retry then ack: single gap, data delivered, no rty.
        mem[24'h000700] = 32'h12345678;
        rty_left = 1;
        @(negedge clk);
        push_exp(1'b1, 1'b0, 32'h12345678);
        fork
            master_req(1, 24'h000700, 32'h0, 1'b0);
            watch_phases(1, 2, "t4");
        join

        // Reset during the retry gap.
        rty_always = 1'b1;
        @(negedge clk);
        m_adr[0] = 24'h000800; m_wdat[0] = 32'h55AA55AA; m_we[0] = 1'b1; m_stb[0] = 1'b1;
        wait_for_gap("t5w");
        @(negedge clk);
        rst_ni = 1'b0;
        exp_dat[0] = 32'd0;
        exp_dat[1] = 32'd0;
        #1;
        check_reset_outputs("t5w");
        m_stb[0]   = 1'b0;
        rty_always = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;

        // Reset while s_stb_o is high; request held through release is re-granted cleanly.
        slave_lat = 3;
        @(negedge clk);
        m_adr[0] = 24'h000900; m_we[0] = 1'b0; m_stb[0] = 1'b1;
        @(negedge clk);
        check("t5b_busy", 32'(s_stb_o), 32'd1);
        rst_ni = 1'b0;
        exp_dat[0] = 32'd0;
        exp_dat[1] = 32'd0;
        #1;
        check_reset_outputs("t5b");
        @(negedge clk);
        rst_ni = 1'b1;
        push_exp(1'b0, 1'b0, 32'h5A000900);
        fork
            master_req(0, 24'h000900, 32'h0, 1'b0);
            begin
                @(negedge clk);
                check("t5b_regrant_stb", 32'(s_stb_o), 32'd1);
                check("t5b_regrant_adr", 32'(s_adr_o), 32'h000900);
            end
        join
        slave_lat = 1;

        // Granted master abandons during the gap; pending master is granted next.
        rty_always = 1'b1;
        @(negedge clk);
        m_adr[0] = 24'h000A00; m_we[0] = 1'b0; m_stb[0] = 1'b1;
        @(negedge clk);
        m_adr[1] = 24'h000B00; m_we[1] = 1'b0; m_stb[1] = 1'b1;
        wait_for_gap("t6");
        m_stb[0]   = 1'b0;
        rty_always = 1'b0;
        @(negedge clk);
        check("t6_abort_stb", 32'(s_stb_o),  32'd0);
        check("t6_abort_ack", 32'(m_ack[0]), 32'd0);
        check("t6_abort_rty", 32'(m_rty[0]), 32'd0);
        push_exp(1'b1, 1'b0, 32'h5A000B00);
        @(negedge clk);
        check("t6_regrant_stb", 32'(s_stb_o), 32'd1);
        check("t6_regrant_adr", 32'(s_adr_o), 32'h000B00);
        master_req(1, 24'h000B00, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
